// File: rtl/trace_event_arbiter.sv
// Collects OpTiMSoC l.nop trace events from several cores into per-core FIFOs
// and round-robin merges them onto a single valid/ready event stream.
module trace_event_arbiter #(
    parameter int unsigned NUM_CORES  = 4,
    parameter int unsigned CORE_ID_W  = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CORES-1:0]    core_enable,
    input  logic [32*NUM_CORES-1:0] core_insn,
    input  logic [32*NUM_CORES-1:0] core_r3,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CORE_ID_W-1:0]    out_core_id,
    output logic [15:0]             out_event_id,
    output logic [31:0]             out_value,
    output logic                    out_lost,
    output logic [NUM_CORES-1:0]    terminated,
    output logic                    all_terminated,
    output logic [15:0]             drop_count
);
    localparam int unsigned ADDR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned PTR_W  = ADDR_W + 1;
    localparam int unsigned SUM_W  = 17;

    typedef struct packed {
        logic [15:0] id;
        logic [31:0] value;
        logic        lost;
    } event_t;

    event_t               mem [NUM_CORES][FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr [NUM_CORES];
    logic [PTR_W-1:0]     rd_ptr [NUM_CORES];
    logic [NUM_CORES-1:0] drop_pending;
    logic [CORE_ID_W-1:0] rr_ptr;

    event_t               ev_data [NUM_CORES];
    logic [NUM_CORES-1:0] ev_hit;
    logic [NUM_CORES-1:0] fifo_full;
    logic [NUM_CORES-1:0] fifo_empty;
    logic [NUM_CORES-1:0] push;
    logic [NUM_CORES-1:0] drop;
    logic [NUM_CORES-1:0] pop;
    logic [NUM_CORES-1:0] terminated_nxt;
    logic                 load;
    logic                 grant_valid;
    logic [CORE_ID_W-1:0] grant;
    logic [CORE_ID_W-1:0] cand;
    event_t               head;
    logic [SUM_W-1:0]     drop_sum;
    logic [15:0]          drop_count_nxt;

    function automatic logic [CORE_ID_W-1:0] wrap_idx(input logic [CORE_ID_W-1:0] base,
                                                      input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= NUM_CORES) sum = sum - NUM_CORES;
        return CORE_ID_W'(sum);
    endfunction

    // Per-core decode and FIFO status
    always_comb begin
        for (int i = 0; i < NUM_CORES; i++) begin
            ev_hit[i]           = core_enable[i]
                                  && (core_insn[32*i+16 +: 16] == 16'h1500)
                                  && (core_insn[32*i +: 16] != 16'h0000);
            ev_data[i].id       = core_insn[32*i +: 16];
            ev_data[i].value    = core_r3[32*i +: 32];
            ev_data[i].lost     = drop_pending[i];
            fifo_empty[i]       = (wr_ptr[i] == rd_ptr[i]);
            fifo_full[i]        = (wr_ptr[i][PTR_W-1] != rd_ptr[i][PTR_W-1])
                                  && (wr_ptr[i][ADDR_W-1:0] == rd_ptr[i][ADDR_W-1:0]);
        end
    end

    // Round-robin pick of the first non-empty FIFO starting at rr_ptr
    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        cand        = '0;
        for (int unsigned k = 0; k < NUM_CORES; k++) begin
            cand = wrap_idx(rr_ptr, k);
            if (!grant_valid && !fifo_empty[cand]) begin
                grant_valid = 1'b1;
                grant       = cand;
            end
        end
        load = !out_valid || out_ready;
        pop  = '0;
        if (load && grant_valid) pop[grant] = 1'b1;
        head = mem[grant][rd_ptr[grant][ADDR_W-1:0]];
    end

    // A full FIFO still accepts a push when it is drained on the same edge
    always_comb begin
        drop_sum = SUM_W'(drop_count);
        for (int i = 0; i < NUM_CORES; i++) begin
            push[i]           = ev_hit[i] && (!fifo_full[i] || pop[i]);
            drop[i]           = ev_hit[i] && !push[i];
            terminated_nxt[i] = terminated[i]
                                || (ev_hit[i] && (core_insn[32*i +: 16] == 16'h0001));
            drop_sum          = drop_sum + SUM_W'(drop[i]);
        end
        drop_count_nxt = (drop_sum > SUM_W'(16'hFFFF)) ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CORES; i++) begin
            if (!rst && push[i]) mem[i][wr_ptr[i][ADDR_W-1:0]] <= ev_data[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CORES; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
            drop_pending   <= '0;
            rr_ptr         <= '0;
            terminated     <= '0;
            all_terminated <= 1'b0;
            drop_count     <= '0;
            out_valid      <= 1'b0;
            out_core_id    <= '0;
            out_event_id   <= '0;
            out_value      <= '0;
            out_lost       <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                if (push[i])      drop_pending[i] <= 1'b0;
                else if (drop[i]) drop_pending[i] <= 1'b1;
            end
            terminated     <= terminated_nxt;
            all_terminated <= &terminated_nxt;
            drop_count     <= drop_count_nxt;
            if (load) begin
                out_valid <= grant_valid;
                if (grant_valid) begin
                    rr_ptr       <= wrap_idx(grant, 1);
                    out_core_id  <= grant;
                    out_event_id <= head.id;
                    out_value    <= head.value;
                    out_lost     <= head.lost;
                end
            end
        end
    end
endmodule

// File: tb/tb_trace_event_arbiter.sv
// Directed bench for trace_event_arbiter: decode, arbitration, backpressure,
// drops, termination and reset behaviour.
module tb_trace_event_arbiter;
    localparam int unsigned NUM_CORES  = 4;
    localparam int unsigned CORE_ID_W  = 2;
    localparam int unsigned FIFO_DEPTH = 4;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_CORES-1:0]    core_enable;
    logic [32*NUM_CORES-1:0] core_insn;
    logic [32*NUM_CORES-1:0] core_r3;
    logic                    out_valid;
    logic                    out_ready;
    logic [CORE_ID_W-1:0]    out_core_id;
    logic [15:0]             out_event_id;
    logic [31:0]             out_value;
    logic                    out_lost;
    logic [NUM_CORES-1:0]    terminated;
    logic                    all_terminated;
    logic [15:0]             drop_count;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    trace_event_arbiter #(
        .NUM_CORES (NUM_CORES),
        .CORE_ID_W (CORE_ID_W),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .core_enable   (core_enable),
        .core_insn     (core_insn),
        .core_r3       (core_r3),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_core_id   (out_core_id),
        .out_event_id  (out_event_id),
        .out_value     (out_value),
        .out_lost      (out_lost),
        .terminated    (terminated),
        .all_terminated(all_terminated),
        .drop_count    (drop_count)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge
    task automatic step();
        @(negedge clk);
    endtask

    task automatic clear_ev();
        core_enable = '0;
        core_insn   = '0;
        core_r3     = '0;
    endtask

    task automatic drive_ev(input int c, input logic [15:0] id, input logic [31:0] r3);
        core_enable[c]        = 1'b1;
        core_insn[32*c +: 32] = {16'h1500, id};
        core_r3[32*c +: 32]   = r3;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_ev();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        out_ready = 1'b0;
        clear_ev();
        step();
        step();
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %0h want 0", out_valid); else pass_cnt++;
        chk_cnt++; if (out_event_id !== 16'h0) $display("FAIL reset_event_id: got %0h want 0", out_event_id); else pass_cnt++;
        chk_cnt++; if (out_value !== 32'h0) $display("FAIL reset_value: got %0h want 0", out_value); else pass_cnt++;
        chk_cnt++; if (terminated !== 4'h0) $display("FAIL reset_terminated: got %0h want 0", terminated); else pass_cnt++;
        chk_cnt++; if (drop_count !== 16'h0) $display("FAIL reset_drop_count: got %0h want 0", drop_count); else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_ignore();
        do_reset();
        out_ready = 1'b1;
        core_enable = 4'b0011;
        core_insn[31:0]  = 32'h1500_0000;
        core_insn[63:32] = 32'h1501_0003;
        core_insn[95:64] = 32'h1500_0001;
        step();
        clear_ev();
        step();
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL ignore_valid: got %0h want 0", out_valid); else pass_cnt++;
        chk_cnt++; if (terminated !== 4'h0) $display("FAIL ignore_terminated: got %0h want 0", terminated); else pass_cnt++;
    endtask

    task automatic test_single();
        do_reset();
        out_ready = 1'b1;
        drive_ev(2, 16'h0004, 32'h41);
        step();
        clear_ev();
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL single_early: got %0h want 0", out_valid); else pass_cnt++;
        step();
        chk_cnt++; if (out_valid !== 1'b1) $display("FAIL single_valid: got %0h want 1", out_valid); else pass_cnt++;
        chk_cnt++; if (out_core_id !== 2'd2) $display("FAIL single_core_id: got %0h want 2", out_core_id); else pass_cnt++;
        chk_cnt++; if (out_event_id !== 16'h0004) $display("FAIL single_event_id: got %0h want 4", out_event_id); else pass_cnt++;
        chk_cnt++; if (out_value !== 32'h41) $display("FAIL single_value: got %0h want 41", out_value); else pass_cnt++;
        chk_cnt++; if (out_lost !== 1'b0) $display("FAIL single_lost: got %0h want 0", out_lost); else pass_cnt++;
        step();
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL single_done: got %0h want 0", out_valid); else pass_cnt++;
    endtask

    task automatic test_fairness();
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) drive_ev(c, 16'(16'h0010 + c), 32'(32'h100 + c));
        step();
        clear_ev();
        step();
        for (int c = 0; c < 4; c++) begin
            chk_cnt++; if (out_valid !== 1'b1 || out_core_id !== 2'(c) || out_event_id !== 16'(16'h0010 + c))
                $display("FAIL fair_slot%0d: got v=%0h core=%0h id=%0h want v=1 core=%0d id=%0h",
                         c, out_valid, out_core_id, out_event_id, c, 16'h0010 + c);
            else pass_cnt++;
            step();
        end
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL fair_drained: got %0h want 0", out_valid); else pass_cnt++;
        // rr_ptr should be back at 0, so core 0 beats core 3
        drive_ev(3, 16'h0033, 32'h3);
        drive_ev(0, 16'h0030, 32'h0);
        step();
        clear_ev();
        step();
        chk_cnt++; if (out_core_id !== 2'd0) $display("FAIL fair_rr_first: got %0h want 0", out_core_id); else pass_cnt++;
        step();
        chk_cnt++; if (out_core_id !== 2'd3) $display("FAIL fair_rr_second: got %0h want 3", out_core_id); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic [15:0] exp_ids [5];
        exp_ids = '{16'd2, 16'd3, 16'd4, 16'd5, 16'd7};
        do_reset();
        out_ready = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            drive_ev(0, 16'(n), 32'(32'hA0 + n));
            step();
        end
        clear_ev();
        chk_cnt++; if (out_valid !== 1'b1 || out_event_id !== 16'd1) $display("FAIL bp_hold: got v=%0h id=%0h want v=1 id=1", out_valid, out_event_id); else pass_cnt++;
        chk_cnt++; if (drop_count !== 16'd1) $display("FAIL bp_drop_count: got %0d want 1", drop_count); else pass_cnt++;
        step();
        chk_cnt++; if (out_event_id !== 16'd1 || out_value !== 32'hA1) $display("FAIL bp_stable: got id=%0h val=%0h want id=1 val=a1", out_event_id, out_value); else pass_cnt++;
        drive_ev(0, 16'd7, 32'hA7);
        out_ready = 1'b1;
        step();
        clear_ev();
        for (int j = 0; j < 5; j++) begin
            chk_cnt++; if (out_valid !== 1'b1 || out_event_id !== exp_ids[j] || out_lost !== (j == 4))
                $display("FAIL bp_drain%0d: got v=%0h id=%0h lost=%0h want v=1 id=%0h lost=%0d",
                         j, out_valid, out_event_id, out_lost, exp_ids[j], (j == 4));
            else pass_cnt++;
            step();
        end
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL bp_empty: got %0h want 0", out_valid); else pass_cnt++;
        chk_cnt++; if (drop_count !== 16'd1) $display("FAIL bp_drop_final: got %0d want 1", drop_count); else pass_cnt++;
    endtask

    task automatic test_full_pop();
        do_reset();
        out_ready = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            drive_ev(1, 16'(16'h0020 + n), 32'(n));
            step();
        end
        drive_ev(1, 16'h0026, 32'h6);
        out_ready = 1'b1;
        step();
        clear_ev();
        chk_cnt++; if (drop_count !== 16'd0) $display("FAIL fullpop_drop_count: got %0d want 0", drop_count); else pass_cnt++;
        for (int j = 0; j < 5; j++) begin
            chk_cnt++; if (out_valid !== 1'b1 || out_core_id !== 2'd1 || out_event_id !== 16'(16'h0022 + j) || out_lost !== 1'b0)
                $display("FAIL fullpop_drain%0d: got v=%0h core=%0h id=%0h lost=%0h want v=1 core=1 id=%0h lost=0",
                         j, out_valid, out_core_id, out_event_id, out_lost, 16'h0022 + j);
            else pass_cnt++;
            step();
        end
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL fullpop_empty: got %0h want 0", out_valid); else pass_cnt++;
    endtask

    task automatic test_termination();
        int term_seen;
        term_seen = 0;
        do_reset();
        out_ready = 1'b1;
        for (int cyc = 0; cyc <= 25; cyc++) begin
            if (cyc > 0) begin
                chk_cnt++; if (all_terminated !== ((cyc - 1) >= 20))
                    $display("FAIL term_all_c%0d: got %0h want %0d", cyc - 1, all_terminated, ((cyc - 1) >= 20));
                else pass_cnt++;
            end
            if (out_valid === 1'b1 && out_event_id === 16'h0001) term_seen++;
            clear_ev();
            if (cyc == 10) drive_ev(0, 16'h0001, 32'h10);
            if (cyc == 12) begin
                drive_ev(1, 16'h0001, 32'h11);
                drive_ev(2, 16'h0001, 32'h12);
            end
            if (cyc == 20) drive_ev(3, 16'h0001, 32'h13);
            step();
        end
        clear_ev();
        chk_cnt++; if (term_seen !== 4) $display("FAIL term_events: got %0d want 4", term_seen); else pass_cnt++;
        chk_cnt++; if (terminated !== 4'hF) $display("FAIL term_flags: got %0h want f", terminated); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b0;
        drive_ev(0, 16'h0005, 32'h50);
        drive_ev(2, 16'h0006, 32'h60);
        drive_ev(3, 16'h0001, 32'h70);
        step();
        clear_ev();
        drive_ev(0, 16'h0007, 32'h80);
        step();
        clear_ev();
        chk_cnt++; if (out_valid !== 1'b1 || terminated !== 4'b1000) $display("FAIL rmid_pre: got v=%0h term=%0h want v=1 term=8", out_valid, terminated); else pass_cnt++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL rmid_valid: got %0h want 0", out_valid); else pass_cnt++;
        chk_cnt++; if (out_core_id !== 2'd0 || out_event_id !== 16'h0 || out_value !== 32'h0 || out_lost !== 1'b0)
            $display("FAIL rmid_fields: got core=%0h id=%0h val=%0h lost=%0h want all 0", out_core_id, out_event_id, out_value, out_lost);
        else pass_cnt++;
        chk_cnt++; if (terminated !== 4'h0 || all_terminated !== 1'b0 || drop_count !== 16'h0)
            $display("FAIL rmid_status: got term=%0h all=%0h drops=%0h want all 0", terminated, all_terminated, drop_count);
        else pass_cnt++;
        out_ready = 1'b1;
        step();
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL rmid_flushed: got %0h want 0", out_valid); else pass_cnt++;
        drive_ev(1, 16'h0055, 32'h1234);
        step();
        clear_ev();
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL rmid_early: got %0h want 0", out_valid); else pass_cnt++;
        step();
        chk_cnt++; if (out_valid !== 1'b1 || out_core_id !== 2'd1 || out_event_id !== 16'h0055 || out_value !== 32'h1234)
            $display("FAIL rmid_event: got v=%0h core=%0h id=%0h val=%0h want v=1 core=1 id=55 val=1234",
                     out_valid, out_core_id, out_event_id, out_value);
        else pass_cnt++;
        step();
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL rmid_done: got %0h want 0", out_valid); else pass_cnt++;
    endtask

    initial begin
        rst       = 1'b1;
        out_ready = 1'b0;
        clear_ev();
        test_reset();
        test_ignore();
        test_single();
        test_fairness();
        test_backpressure();
        test_full_pop();
        test_termination();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
